// File: rtl/writeback_pkg.sv
// Shared opcode constants and instruction field helpers
// for the 16-bit CPU writeback stage.
package writeback_pkg;

  localparam int W     = 16;
  localparam int NREGS = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_AND  = 4'b0011,
    OP_OR   = 4'b0100,
    OP_LW   = 4'b0101,
    OP_SW   = 4'b0110,
    OP_JUMP = 4'b0111
  } op_e;

  function automatic logic [3:0] GET_OP(
    input logic [15:0] ir
  );
    return ir[15:12];
  endfunction

  function automatic logic [3:0] GET_RD(
    input logic [15:0] ir
  );
    return ir[11:8];
  endfunction

  function automatic logic [3:0] GET_RA(
    input logic [15:0] ir
  );
    return ir[7:4];
  endfunction

  function automatic logic [3:0] GET_RB(
    input logic [15:0] ir
  );
    return ir[3:0];
  endfunction

  function automatic logic writes_reg(
    input logic [3:0] op
  );
    logic r;
    r = 1'b0;
    case (op)
      OP_ADD, OP_SUB,
      OP_AND, OP_OR,
      OP_LW:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/writeback_if.sv
// Bundle between memory-write/decode stages and
// the writeback stage.
interface writeback_if;
  import writeback_pkg::*;

  logic         STAGE5IN;
  logic [W-1:0] IRIN;
  logic [W-1:0] ADDRIN;
  logic [W-1:0] DATAIN;
  logic [W-1:0] MEMDATA;
  logic [3:0]   RADDR_A;
  logic [3:0]   RADDR_B;
  logic [W-1:0] RDATA_A;
  logic [W-1:0] RDATA_B;
  logic         WB_ON;
  logic [3:0]   WB_REG;
  logic [W-1:0] WB_DATA;
  logic [W-1:0] RETIRED;

  modport master (
    output STAGE5IN, IRIN, ADDRIN,
    output DATAIN, MEMDATA,
    output RADDR_A, RADDR_B,
    input  RDATA_A, RDATA_B,
    input  WB_ON, WB_REG, WB_DATA,
    input  RETIRED
  );

  modport slave (
    input  STAGE5IN, IRIN, ADDRIN,
    input  DATAIN, MEMDATA,
    input  RADDR_A, RADDR_B,
    output RDATA_A, RDATA_B,
    output WB_ON, WB_REG, WB_DATA,
    output RETIRED
  );

endinterface

// File: rtl/regfile_16x16.sv
// General register file: r0 hardwired to zero,
// one sync write port, two bypassed comb read ports.
module regfile_16x16
  import writeback_pkg::*;
#(
  parameter int NR = NREGS,
  parameter int DW = W,
  localparam int AW = $clog2(NR)
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_a,
  output logic [DW-1:0] o_rdata_b
);

  logic [DW-1:0] r_mem [NR];
  logic          w_we;
  logic          w_byp_a;
  logic          w_byp_b;

  assign w_we = i_we && !i_clr
             && (i_waddr != '0);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < NR; i++)
        r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign w_byp_a = w_we
                && (i_raddr_a == i_waddr);
  assign w_byp_b = w_we
                && (i_raddr_b == i_waddr);

  always_comb begin
    o_rdata_a = '0;
    o_rdata_b = '0;
    if (i_raddr_a != '0)
      o_rdata_a = w_byp_a ? i_wdata
                          : r_mem[i_raddr_a];
    if (i_raddr_b != '0)
      o_rdata_b = w_byp_b ? i_wdata
                          : r_mem[i_raddr_b];
  end

endmodule

// File: rtl/writeback.sv
// Stage 5: commits ALU/load results to the
// register file and counts retired instructions.
module writeback
  import writeback_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  writeback_if.slave  bus
);

  logic [3:0]   w_op;
  logic [3:0]   w_rd;
  logic         w_we;
  logic [W-1:0] w_wdata;

  logic         r_wb_on;
  logic [3:0]   r_wb_reg;
  logic [W-1:0] r_wb_data;
  logic [W-1:0] r_retired;

  assign w_op = GET_OP(bus.IRIN);
  assign w_rd = GET_RD(bus.IRIN);

  assign w_we = bus.STAGE5IN
             && writes_reg(w_op)
             && (w_rd != 4'd0);

  assign w_wdata = (w_op == OP_LW)
                 ? bus.MEMDATA
                 : bus.DATAIN;

  regfile_16x16 #(
    .NR (NREGS),
    .DW (W)
  ) u_rf (
    .i_clk     (CLK),
    .i_clr     (RST),
    .i_we      (w_we),
    .i_waddr   (w_rd),
    .i_wdata   (w_wdata),
    .i_raddr_a (bus.RADDR_A),
    .i_raddr_b (bus.RADDR_B),
    .o_rdata_a (bus.RDATA_A),
    .o_rdata_b (bus.RDATA_B)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wb_on   <= 1'b0;
      r_wb_reg  <= '0;
      r_wb_data <= '0;
      r_retired <= '0;
    end else begin
      r_wb_on   <= w_we;
      r_wb_reg  <= w_we ? w_rd : '0;
      r_wb_data <= w_we ? w_wdata : '0;
      if (bus.STAGE5IN)
        r_retired <= r_retired + 1'b1;
    end
  end

  assign bus.WB_ON   = r_wb_on;
  assign bus.WB_REG  = r_wb_reg;
  assign bus.WB_DATA = r_wb_data;
  assign bus.RETIRED = r_retired;

endmodule

// File: tb/tb_writeback.sv
// Directed vector bench for the writeback stage.
module tb_writeback;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  writeback_if bus ();

  writeback dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] ir;
    logic [15:0] data;
    logic [15:0] mem;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] x_ra;
    logic [15:0] x_rb;
    logic        x_on;
    logic [3:0]  x_reg;
    logic [15:0] x_dat;
    logic [15:0] x_ret;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(
    input string       name,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  task automatic drive(
    input logic        v,
    input logic [15:0] ir,
    input logic [15:0] data,
    input logic [15:0] mem,
    input logic [3:0]  ra,
    input logic [3:0]  rb
  );
    bus.STAGE5IN = v;
    bus.IRIN     = ir;
    bus.ADDRIN   = ir ^ 16'h5A5A;
    bus.DATAIN   = data;
    bus.MEMDATA  = mem;
    bus.RADDR_A  = ra;
    bus.RADDR_B  = rb;
  endtask

  initial begin
    //        v  ir       data     mem      ra rb  x_ra     x_rb     on reg x_dat    ret
    tbl[0]  = '{1, 16'h1312, 16'h00A5, 16'h0000, 3, 0, 16'h00A5, 16'h0000, 1, 3, 16'h00A5, 1};
    tbl[1]  = '{1, 16'h5400, 16'h1234, 16'hBEEF, 4, 3, 16'hBEEF, 16'h00A5, 1, 4, 16'hBEEF, 2};
    tbl[2]  = '{1, 16'h1500, 16'h0F0F, 16'h0000, 5, 5, 16'h0F0F, 16'h0F0F, 1, 5, 16'h0F0F, 3};
    tbl[3]  = '{0, 16'h0000, 16'h0000, 16'h0000, 5, 4, 16'h0F0F, 16'hBEEF, 0, 0, 16'h0000, 3};
    tbl[4]  = '{1, 16'h1000, 16'hFFFF, 16'h0000, 0, 3, 16'h0000, 16'h00A5, 0, 0, 16'h0000, 4};
    tbl[5]  = '{1, 16'h6120, 16'h1111, 16'h0000, 1, 2, 16'h0000, 16'h0000, 0, 0, 16'h0000, 5};
    tbl[6]  = '{1, 16'h7000, 16'h2222, 16'h0000, 3, 4, 16'h00A5, 16'hBEEF, 0, 0, 16'h0000, 6};
    tbl[7]  = '{0, 16'h1300, 16'h9999, 16'h0000, 3, 5, 16'h00A5, 16'h0F0F, 0, 0, 16'h0000, 6};
    tbl[8]  = '{0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 6};
    tbl[9]  = '{0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 6};
    tbl[10] = '{1, 16'h1700, 16'h1111, 16'h0000, 7, 7, 16'h1111, 16'h1111, 1, 7, 16'h1111, 7};
    tbl[11] = '{1, 16'h1700, 16'h2222, 16'h0000, 7, 5, 16'h2222, 16'h0F0F, 1, 7, 16'h2222, 8};
    tbl[12] = '{0, 16'h0000, 16'h0000, 16'h0000, 7, 3, 16'h2222, 16'h00A5, 0, 0, 16'h0000, 8};
    tbl[13] = '{1, 16'h8300, 16'h5555, 16'h0000, 3, 0, 16'h00A5, 16'h0000, 0, 0, 16'h0000, 9};

    drive(0, 0, 0, 0, 3, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ret",  bus.RETIRED, 16'h0);
    chk("rst_on",   {15'b0, bus.WB_ON}, 16'h0);
    chk("rst_reg",  {12'b0, bus.WB_REG}, 16'h0);
    chk("rst_dat",  bus.WB_DATA, 16'h0);
    chk("rst_r3",   bus.RDATA_A, 16'h0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].ir, tbl[i].data,
            tbl[i].mem, tbl[i].ra, tbl[i].rb);
      #1;
      chk($sformatf("v%0d_rda", i),
          bus.RDATA_A, tbl[i].x_ra);
      chk($sformatf("v%0d_rdb", i),
          bus.RDATA_B, tbl[i].x_rb);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_on", i),
          {15'b0, bus.WB_ON}, {15'b0, tbl[i].x_on});
      chk($sformatf("v%0d_reg", i),
          {12'b0, bus.WB_REG}, {12'b0, tbl[i].x_reg});
      chk($sformatf("v%0d_dat", i),
          bus.WB_DATA, tbl[i].x_dat);
      chk($sformatf("v%0d_ret", i),
          bus.RETIRED, tbl[i].x_ret);
    end

    // one-cycle pulse: WB_ON clears after vector 11
    @(negedge clk);
    drive(0, 0, 0, 0, 4, 7);
    #1;
    chk("post_on", {15'b0, bus.WB_ON}, 16'h0);
    chk("post_r4", bus.RDATA_A, 16'hBEEF);
    chk("post_r7", bus.RDATA_B, 16'h2222);

    // counter wrap from a fresh reset
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 16'h0000, 0, 0, 0, 0);
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_ffff", bus.RETIRED, 16'hFFFF);
    @(posedge clk);
    #1;
    chk("wrap_0000", bus.RETIRED, 16'h0000);

    // write r6, then reset collides with another ADD r6
    @(negedge clk);
    drive(1, 16'h1600, 16'h1234, 0, 6, 0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 16'h1600, 16'hABCD, 0, 6, 6);
    rst = 1'b1;
    #1;
    chk("pre_rst_r6", bus.RDATA_A, 16'h1234);
    @(posedge clk);
    #1;
    chk("rw_ret", bus.RETIRED, 16'h0);
    chk("rw_on",  {15'b0, bus.WB_ON}, 16'h0);
    chk("rw_dat", bus.WB_DATA, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 6, 6);
    #1;
    chk("rw_r6a", bus.RDATA_A, 16'h0);
    chk("rw_r6b", bus.RDATA_B, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
